// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: double-buffered frame scheduler for a streaming FFT core.
// Incoming samples are written into one of two RAM banks. When a bank fills and
// the core is idle, the banks swap and the full bank is read out into the core.
// The core is then sequenced through start, early-done, unload and output drain.
// Ports:
//   clock, reset             rising-edge clock, asynchronous active-low reset
//   strobe                   one input sample valid this cycle
//   set_stb/addr/data        settings bus: +0 enable, +1 skip_cnt, +2 overrun clear
//   e_done_fft_core          core early-done pulse
//   dv_fft_core              core output data valid
//   *_fft_core outputs       registered single-cycle core control pulses
//   wr_en_ram_*, addr_ram_*  bank write enables / addresses (same-cycle decode)
//   sel_ram                  bank currently being written
//   overrun                  sticky: a full frame was dropped because the core was busy
module fft_frame_scheduler #(
  parameter logic [7:0]  SR_BASE    = 8'd0,
  parameter int unsigned FRAME_LOG2 = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  strobe,
  input  logic                  set_stb,
  input  logic [7:0]            set_addr,
  input  logic [31:0]           set_data,
  input  logic                  e_done_fft_core,
  input  logic                  dv_fft_core,
  output logic                  sclr_fft_core,
  output logic                  scale_sch_we_fft_core,
  output logic                  start_fft_core,
  output logic                  unload_fft_core,
  output logic                  wr_en_ram_0,
  output logic                  wr_en_ram_1,
  output logic [FRAME_LOG2-1:0] addr_ram_0,
  output logic [FRAME_LOG2-1:0] addr_ram_1,
  output logic                  sel_ram,
  output logic                  overrun
);

  localparam int unsigned AW = FRAME_LOG2;
  localparam logic [AW-1:0] LAST = {AW{1'b1}};

  typedef enum logic [2:0] {
    S_INIT, S_CFG, S_IDLE, S_LOAD, S_WAIT_EDONE, S_UNLOAD, S_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic          enable_q, enable_d;
  logic [7:0]    skip_cnt_q, skip_cnt_d;
  logic [7:0]    skip_ctr_q, skip_ctr_d;
  logic          overrun_q, overrun_d;
  logic          sel_q, sel_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] dv_cnt_q, dv_cnt_d;
  logic          sclr_q, sclr_d;
  logic          scale_q, scale_d;
  logic          start_q, start_d;
  logic          unload_q, unload_d;

  logic          wr_fire, frame_full, accept, drop_busy;
  logic          hit_en, hit_skip, hit_clr;
  logic [AW-1:0] rd_addr_out;
  logic          unused_set_data;

  // Only the low byte of the settings data is meaningful.
  assign unused_set_data = ^set_data[31:8];

  // Settings-bus decode.
  assign hit_en   = set_stb && (set_addr == SR_BASE);
  assign hit_skip = set_stb && (set_addr == SR_BASE + 8'd1);
  assign hit_clr  = set_stb && (set_addr == SR_BASE + 8'd2);

  // Frame-completion events on the write side.
  assign wr_fire    = enable_q && strobe;
  assign frame_full = wr_fire && (wr_addr_q == LAST);
  assign accept     = frame_full && (skip_ctr_q == 8'd0) && (state_q == S_IDLE);
  assign drop_busy  = frame_full && (skip_ctr_q == 8'd0) && (state_q != S_IDLE);

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    enable_d   = enable_q;
    skip_cnt_d = skip_cnt_q;
    skip_ctr_d = skip_ctr_q;
    overrun_d  = overrun_q;
    sel_d      = sel_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    dv_cnt_d   = dv_cnt_q;

    if (hit_en)   enable_d   = set_data[0];
    if (hit_skip) skip_cnt_d = set_data[7:0];
    if (hit_clr)  overrun_d  = 1'b0;
    // A drop in the same cycle as a clear leaves the flag set.
    if (drop_busy) overrun_d = 1'b1;

    if (!enable_q) begin
      wr_addr_d  = '0;
      skip_ctr_d = 8'd0;
    end else if (wr_fire) begin
      wr_addr_d = wr_addr_q + AW'(1);
      if (frame_full) begin
        if (skip_ctr_q != 8'd0) begin
          skip_ctr_d = skip_ctr_q - 8'd1;
        end else if (accept) begin
          sel_d      = ~sel_q;
          skip_ctr_d = skip_cnt_q;
        end
      end
    end

    case (state_q)
      S_INIT:       state_d = S_CFG;
      S_CFG:        state_d = S_IDLE;
      S_IDLE:       if (accept) state_d = S_LOAD;
      S_LOAD: begin
        rd_addr_d = rd_addr_q + AW'(1);
        if (rd_addr_q == LAST) state_d = S_WAIT_EDONE;
      end
      S_WAIT_EDONE: if (e_done_fft_core) state_d = S_UNLOAD;
      S_UNLOAD:     state_d = S_DRAIN;
      S_DRAIN: begin
        if (dv_fft_core) begin
          dv_cnt_d = dv_cnt_q + AW'(1);
          if (dv_cnt_q == LAST) state_d = S_IDLE;
        end
      end
      default:      state_d = S_INIT;
    endcase

    // Pulses line up with the cycle their state is (or was just) active.
    sclr_d   = (state_q == S_INIT);
    scale_d  = (state_q == S_CFG);
    start_d  = (state_q == S_IDLE) && (state_d == S_LOAD);
    unload_d = (state_d == S_UNLOAD);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_INIT;
      enable_q   <= 1'b0;
      skip_cnt_q <= 8'd0;
      skip_ctr_q <= 8'd0;
      overrun_q  <= 1'b0;
      sel_q      <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dv_cnt_q   <= '0;
      sclr_q     <= 1'b0;
      scale_q    <= 1'b0;
      start_q    <= 1'b0;
      unload_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      skip_cnt_q <= skip_cnt_d;
      skip_ctr_q <= skip_ctr_d;
      overrun_q  <= overrun_d;
      sel_q      <= sel_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      dv_cnt_q   <= dv_cnt_d;
      sclr_q     <= sclr_d;
      scale_q    <= scale_d;
      start_q    <= start_d;
      unload_q   <= unload_d;
    end
  end

  // Read bank address runs only while loading the core.
  assign rd_addr_out = (state_q == S_LOAD) ? rd_addr_q : '0;

  // Bank steering: sel_ram picks the write bank, the other bank feeds the core.
  assign wr_en_ram_0 = wr_fire && !sel_q;
  assign wr_en_ram_1 = wr_fire &&  sel_q;
  assign addr_ram_0  = sel_q ? rd_addr_out : wr_addr_q;
  assign addr_ram_1  = sel_q ? wr_addr_q   : rd_addr_out;

  assign sclr_fft_core         = sclr_q;
  assign scale_sch_we_fft_core = scale_q;
  assign start_fft_core        = start_q;
  assign unload_fft_core       = unload_q;
  assign sel_ram               = sel_q;
  assign overrun               = overrun_q;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Testbench for fft_frame_scheduler: directed vector table for bring-up and
// settings behaviour, then hand-written sequences for frame swap, core
// sequencing, overrun, frame skipping, enable drop and mid-transform reset.
module tb_fft_frame_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        strobe = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = 8'd0;
  logic [31:0] set_data = 32'd0;
  logic        e_done_fft_core = 1'b0;
  logic        dv_fft_core = 1'b0;
  logic        sclr_fft_core, scale_sch_we_fft_core, start_fft_core, unload_fft_core;
  logic        wr_en_ram_0, wr_en_ram_1;
  logic [9:0]  addr_ram_0, addr_ram_1;
  logic        sel_ram, overrun;

  int n_pass = 0;
  int n_total = 0;
  int start_cnt = 0;
  int unload_cnt = 0;

  typedef struct packed {
    logic       sclr, scale, start, unload, we0, we1;
    logic [9:0] a0, a1;
    logic       sel, ovr;
  } outs_t;

  typedef struct {
    logic        strobe;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    outs_t       exp;
  } vec_t;

  vec_t tbl[12];

  fft_frame_scheduler #(.SR_BASE(8'd0), .FRAME_LOG2(10)) dut (
    .clock(clock), .reset(reset), .strobe(strobe),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .e_done_fft_core(e_done_fft_core), .dv_fft_core(dv_fft_core),
    .sclr_fft_core(sclr_fft_core), .scale_sch_we_fft_core(scale_sch_we_fft_core),
    .start_fft_core(start_fft_core), .unload_fft_core(unload_fft_core),
    .wr_en_ram_0(wr_en_ram_0), .wr_en_ram_1(wr_en_ram_1),
    .addr_ram_0(addr_ram_0), .addr_ram_1(addr_ram_1),
    .sel_ram(sel_ram), .overrun(overrun)
  );

  always #5 clock = ~clock;

  function automatic outs_t mk_o(logic sclr, logic scale, logic start, logic unload,
                                 logic we0, logic we1, logic [9:0] a0, logic [9:0] a1,
                                 logic sel, logic ovr);
    outs_t o;
    o.sclr = sclr; o.scale = scale; o.start = start; o.unload = unload;
    o.we0 = we0; o.we1 = we1; o.a0 = a0; o.a1 = a1; o.sel = sel; o.ovr = ovr;
    return o;
  endfunction

  function automatic outs_t outs_now();
    return mk_o(sclr_fft_core, scale_sch_we_fft_core, start_fft_core, unload_fft_core,
                wr_en_ram_0, wr_en_ram_1, addr_ram_0, addr_ram_1, sel_ram, overrun);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One clock cycle: drive on the falling edge, settle, then sample.
  task automatic drive(input logic s, input logic ss, input logic [7:0] sa,
                       input logic [31:0] sd, input logic ed, input logic d);
    @(negedge clock);
    strobe = s; set_stb = ss; set_addr = sa; set_data = sd;
    e_done_fft_core = ed; dv_fft_core = d;
    #1;
    if (start_fft_core)  start_cnt++;
    if (unload_fft_core) unload_cnt++;
  endtask

  task automatic cyc(input logic s, input logic ed, input logic d);
    drive(s, 1'b0, 8'd0, 32'd0, ed, d);
  endtask

  task automatic set_reg(input logic [7:0] a, input logic [31:0] dat);
    drive(1'b0, 1'b1, a, dat, 1'b0, 1'b0);
  endtask

  // Let a started transform finish: rest of LOAD, early-done, unload, drain.
  task automatic finish_xform();
    for (int i = 0; i < 1030; i++) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 1024; i++) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int errs;
    int start_at;

    tbl[0]  = '{1'b0, 1'b0, 8'd0, 32'd0, mk_o(1,0,0,0, 0,0, 10'd0, 10'd0, 0,0)};
    tbl[1]  = '{1'b0, 1'b0, 8'd0, 32'd0, mk_o(0,1,0,0, 0,0, 10'd0, 10'd0, 0,0)};
    tbl[2]  = '{1'b0, 1'b1, 8'd0, 32'd1, mk_o(0,0,0,0, 0,0, 10'd0, 10'd0, 0,0)};
    tbl[3]  = '{1'b1, 1'b0, 8'd0, 32'd0, mk_o(0,0,0,0, 1,0, 10'd0, 10'd0, 0,0)};
    tbl[4]  = '{1'b0, 1'b0, 8'd0, 32'd0, mk_o(0,0,0,0, 0,0, 10'd1, 10'd0, 0,0)};
    tbl[5]  = '{1'b1, 1'b0, 8'd0, 32'd0, mk_o(0,0,0,0, 1,0, 10'd1, 10'd0, 0,0)};
    tbl[6]  = '{1'b1, 1'b1, 8'd0, 32'd0, mk_o(0,0,0,0, 1,0, 10'd2, 10'd0, 0,0)};
    tbl[7]  = '{1'b1, 1'b0, 8'd0, 32'd0, mk_o(0,0,0,0, 0,0, 10'd3, 10'd0, 0,0)};
    tbl[8]  = '{1'b1, 1'b1, 8'd0, 32'd1, mk_o(0,0,0,0, 0,0, 10'd0, 10'd0, 0,0)};
    tbl[9]  = '{1'b1, 1'b0, 8'd0, 32'd0, mk_o(0,0,0,0, 1,0, 10'd0, 10'd0, 0,0)};
    tbl[10] = '{1'b0, 1'b1, 8'd3, 32'd0, mk_o(0,0,0,0, 0,0, 10'd1, 10'd0, 0,0)};
    tbl[11] = '{1'b1, 1'b0, 8'd0, 32'd0, mk_o(0,0,0,0, 1,0, 10'd1, 10'd0, 0,0)};

    // Held in reset: everything quiet.
    #22;
    chk("reset_outputs", {4'h0, outs_now()}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Bring-up pulses, enable, disable/re-enable, unmapped settings write.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].strobe, tbl[i].set_stb, tbl[i].set_addr, tbl[i].set_data, 1'b0, 1'b0);
      chk($sformatf("vec%0d", i), {4'h0, outs_now()}, {4'h0, tbl[i].exp});
    end

    // Full frame into bank 0, swap, load core from bank 0.
    set_reg(8'd0, 32'd0);
    set_reg(8'd0, 32'd1);
    start_cnt = 0;
    errs = 0;
    for (int i = 0; i < 1024; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (!(wr_en_ram_0 && !wr_en_ram_1 && addr_ram_0 == 10'(i) && !sel_ram)) errs++;
    end
    chk("frame0_writes", 32'(errs), 32'd0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("load_entry_start", 32'(start_fft_core), 32'd1);
    chk("load_entry_sel", 32'(sel_ram), 32'd1);
    chk("load_entry_write", 32'({wr_en_ram_1, wr_en_ram_0, addr_ram_1, addr_ram_0}),
        32'({1'b1, 1'b0, 10'd0, 10'd0}));
    errs = 0;
    for (int k = 1; k < 1024; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (addr_ram_0 != 10'(k) || wr_en_ram_0) errs++;
    end
    chk("load_rd_addr", 32'(errs), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("rd_addr_idle_zero", 32'(addr_ram_0), 32'd0);
    chk("start_once", 32'(start_cnt), 32'd1);

    // Early-done, unload, drain.
    unload_cnt = 0;
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("unload_pulse", 32'(unload_fft_core), 32'd1);
    for (int i = 0; i < 1024; i++) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("unload_once", 32'(unload_cnt), 32'd1);
    chk("no_overrun", 32'(overrun), 32'd0);

    // Overrun: second frame fills while core waits for early-done.
    set_reg(8'd0, 32'd0);
    set_reg(8'd0, 32'd1);
    start_cnt = 0;
    for (int i = 0; i < 1024; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("s2_accept_sel", 32'(sel_ram), 32'd0);
    chk("s2_start", 32'(start_cnt), 32'd1);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 1024; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("overrun_sel_kept", 32'(sel_ram), 32'd0);
    chk("overrun_no_start", 32'(start_cnt), 32'd1);
    set_reg(8'd2, 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("overrun_cleared", 32'(overrun), 32'd0);
    for (int i = 0; i < 1023; i++) cyc(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'd2, 32'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("overrun_set_wins", 32'(overrun), 32'd1);
    set_reg(8'd2, 32'd0);
    set_reg(8'd0, 32'd0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("s2_unload", 32'(unload_fft_core), 32'd1);
    for (int i = 0; i < 1024; i++) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);

    // Skip: prime reload of 2, then only the third frame starts a transform.
    set_reg(8'd1, 32'd2);
    set_reg(8'd0, 32'd1);
    for (int i = 0; i < 1024; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("prime_start", 32'(start_fft_core), 32'd1);
    finish_xform();
    start_cnt = 0;
    start_at = -1;
    for (int i = 0; i < 3073; i++) begin
      cyc(i < 3072, 1'b0, 1'b0);
      if (start_fft_core && start_at < 0) start_at = i;
    end
    chk("skip_start_count", 32'(start_cnt), 32'd1);
    chk("skip_start_cycle", 32'(start_at), 32'd3072);
    chk("skip_sel", 32'(sel_ram), 32'd0);
    chk("skip_no_overrun", 32'(overrun), 32'd0);
    finish_xform();

    // Enable dropped mid-frame: partial frame discarded, restart at address 0.
    set_reg(8'd1, 32'd0);
    for (int i = 0; i < 500; i++) cyc(1'b1, 1'b0, 1'b0);
    set_reg(8'd0, 32'd0);
    set_reg(8'd0, 32'd1);
    start_cnt = 0;
    start_at = -1;
    for (int i = 0; i < 1025; i++) begin
      cyc(i < 1024, 1'b0, 1'b0);
      if (i == 0) chk("reenable_addr0", 32'({wr_en_ram_0, addr_ram_0}), 32'({1'b1, 10'd0}));
      if (start_fft_core && start_at < 0) start_at = i;
    end
    chk("reenable_start_count", 32'(start_cnt), 32'd1);
    chk("reenable_start_cycle", 32'(start_at), 32'd1024);

    // Reset while loading: abort, then full bring-up again.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset_mid_xform", {4'h0, outs_now()}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("restart_sclr", {4'h0, outs_now()}, {4'h0, mk_o(1,0,0,0, 0,0, 10'd0, 10'd0, 0,0)});
    cyc(1'b0, 1'b0, 1'b0);
    chk("restart_scale", {4'h0, outs_now()}, {4'h0, mk_o(0,1,0,0, 0,0, 10'd0, 10'd0, 0,0)});
    cyc(1'b1, 1'b0, 1'b0);
    chk("restart_idle", {4'h0, outs_now()}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
